// File: rtl/adpll_pkg.sv
// Shared ADPLL constants, phase-detector encoding and the PD sample payload.
package adpll_pkg;

  localparam int unsigned CODE_WIDTH_DEF = 4;
  localparam int unsigned FRAC_BITS_DEF  = 8;
  localparam int unsigned ACC_WIDTH_DEF  = 16;
  localparam int unsigned KI_DEF         = 4;
  localparam int unsigned KP_DEF         = 1;
  localparam int unsigned LOCK_COUNT_DEF = 32;

  localparam logic PD_UP   = 1'b1;
  localparam logic PD_DOWN = 1'b0;

  typedef struct packed {
    logic accept;
    logic up;
  } lf_sample_t;

  // Mid-scale DCO code for a given code width.
  function automatic int unsigned mid_code(input int unsigned width);
    return 32'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/lf_lock_detect.sv
// Lock detector: counts consecutive alternating PD decisions and flags lock
// once LOCK_COUNT alternations have been seen in a row.
module lf_lock_detect
  import adpll_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = LOCK_COUNT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  lf_sample_t sample,
  output logic       lock
);

  localparam int unsigned CNT_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_COUNT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             have_last_q, have_last_d;
  logic             last_up_q, last_up_d;
  logic             lock_q, lock_d;

  always_comb begin
    cnt_d       = cnt_q;
    have_last_d = have_last_q;
    last_up_d   = last_up_q;
    if (!enable) begin
      cnt_d       = '0;
      have_last_d = 1'b0;
    end else if (sample.accept) begin
      if (!have_last_q) begin
        have_last_d = 1'b1;
      end else if (sample.up != last_up_q) begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      end else begin
        cnt_d = '0;
      end
      last_up_d = sample.up;
    end
    lock_d = (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      have_last_q <= 1'b0;
      last_up_q   <= 1'b0;
      lock_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      have_last_q <= have_last_d;
      last_up_q   <= last_up_d;
      lock_q      <= lock_d;
    end
  end

  assign lock = lock_q;

endmodule

// File: rtl/bang_bang_loop_filter.sv
// Digital PI loop filter turning bang-bang PD decisions into the DCO code.
// Lock detection is built only when LF_LOCK_DETECT_EN is defined.
module bang_bang_loop_filter
  import adpll_pkg::*;
#(
  parameter int unsigned CODE_WIDTH = CODE_WIDTH_DEF,
  parameter int unsigned FRAC_BITS  = FRAC_BITS_DEF,
  parameter int unsigned ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int unsigned KI         = KI_DEF,
  parameter int unsigned KP         = KP_DEF,
  parameter int unsigned LOCK_COUNT = LOCK_COUNT_DEF
) (
  input  logic                  fpga_clk_i,
  input  logic                  reset_i,
  input  logic                  enable_i,
  input  logic                  pd_valid_i,
  input  logic                  pd_up_i,
  output logic [CODE_WIDTH-1:0] freq_sel_o,
  output logic                  lock_o,
  output logic [ACC_WIDTH-1:0]  integ_o
);

  localparam int unsigned SUM_W   = ACC_WIDTH + 2;
  localparam int unsigned MID     = mid_code(CODE_WIDTH);
  localparam int unsigned INT_MAX = ((32'(1) << CODE_WIDTH) << FRAC_BITS) - 1;
  localparam int unsigned CMAX    = (32'(1) << CODE_WIDTH) - 1;

  localparam logic [ACC_WIDTH-1:0]    INTEG_RST = ACC_WIDTH'(MID << FRAC_BITS);
  localparam logic [CODE_WIDTH-1:0]   CODE_RST  = CODE_WIDTH'(MID);
  localparam logic signed [SUM_W-1:0] KI_S      = SUM_W'(KI);
  localparam logic signed [SUM_W-1:0] KP_S      = SUM_W'(KP);
  localparam logic signed [SUM_W-1:0] INT_MAX_S = SUM_W'(INT_MAX);
  localparam logic signed [SUM_W-1:0] CMAX_S    = SUM_W'(CMAX);

  generate
    if (ACC_WIDTH < CODE_WIDTH + FRAC_BITS + 1) begin : g_bad_acc_width
      $error("ACC_WIDTH must be >= CODE_WIDTH + FRAC_BITS + 1");
    end
  endgenerate

  logic                    accept_c;
  logic [ACC_WIDTH-1:0]    integ_q, integ_d;
  logic signed [SUM_W-1:0] prop_q, prop_d;
  logic [CODE_WIDTH-1:0]   code_q, code_d;
  logic signed [SUM_W-1:0] integ_sum, code_sum;

  // Stage 1: saturating integrator and proportional term.
  always_comb begin
    accept_c  = enable_i && pd_valid_i;
    integ_d   = integ_q;
    prop_d    = prop_q;
    integ_sum = $signed({2'b00, integ_q}) + ((pd_up_i == PD_UP) ? KI_S : -KI_S);
    if (accept_c) begin
      if (integ_sum < 0) begin
        integ_d = '0;
      end else if (integ_sum > INT_MAX_S) begin
        integ_d = ACC_WIDTH'(INT_MAX);
      end else begin
        integ_d = integ_sum[ACC_WIDTH-1:0];
      end
      prop_d = (pd_up_i == PD_UP) ? KP_S : -KP_S;
    end
  end

  // Stage 2: integer part plus proportional term, clamped to the code range.
  always_comb begin
    code_d   = code_q;
    code_sum = $signed({2'b00, integ_q >> FRAC_BITS}) + prop_q;
    if (enable_i) begin
      if (code_sum < 0) begin
        code_d = '0;
      end else if (code_sum > CMAX_S) begin
        code_d = CODE_WIDTH'(CMAX);
      end else begin
        code_d = code_sum[CODE_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      integ_q <= INTEG_RST;
      prop_q  <= '0;
      code_q  <= CODE_RST;
    end else begin
      integ_q <= integ_d;
      prop_q  <= prop_d;
      code_q  <= code_d;
    end
  end

  assign freq_sel_o = code_q;
  assign integ_o    = integ_q;

`ifdef LF_LOCK_DETECT_EN
  lf_sample_t sample_c;
  assign sample_c = '{accept: accept_c, up: pd_up_i};

  lf_lock_detect #(
    .LOCK_COUNT(LOCK_COUNT)
  ) u_lock_detect (
    .clk    (fpga_clk_i),
    .reset  (reset_i),
    .enable (enable_i),
    .sample (sample_c),
    .lock   (lock_o)
  );
`else
  assign lock_o = 1'b0;
`endif

endmodule

// File: tb/tb_bang_bang_loop_filter.sv
// Directed bench for bang_bang_loop_filter; lock expectations follow LF_LOCK_DETECT_EN.
module tb_bang_bang_loop_filter;

`ifdef LF_LOCK_DETECT_EN
  localparam logic LOCK_ON = 1'b1;
`else
  localparam logic LOCK_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        pd_valid = 1'b0;
  logic        pd_up = 1'b0;
  logic [3:0]  freq_sel;
  logic        lock;
  logic [15:0] integ;

  int total = 0;
  int bad = 0;

  bang_bang_loop_filter dut (
    .fpga_clk_i (clk),
    .reset_i    (reset),
    .enable_i   (enable),
    .pd_valid_i (pd_valid),
    .pd_up_i    (pd_up),
    .freq_sel_o (freq_sel),
    .lock_o     (lock),
    .integ_o    (integ)
  );

  always #5 clk = ~clk;

  task automatic strobe(input logic up);
    pd_valid = 1'b1;
    pd_up    = up;
    @(negedge clk);
    pd_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (freq_sel !== 4'd8) begin bad++; $display("FAIL reset_freq got=%0d exp=8", freq_sel); end
    total++; if (integ !== 16'h0800) begin bad++; $display("FAIL reset_integ got=%0h exp=800", integ); end
    total++; if (lock !== 1'b0) begin bad++; $display("FAIL reset_lock got=%0b exp=0", lock); end
  endtask

  task automatic test_slew();
    strobe(1'b1);
    total++; if (integ !== 16'h0804) begin bad++; $display("FAIL slew_integ1 got=%0h exp=804", integ); end
    total++; if (freq_sel !== 4'd8) begin bad++; $display("FAIL slew_latency got=%0d exp=8", freq_sel); end
    for (int i = 0; i < 15; i++) strobe(1'b1);
    total++; if (integ !== 16'h0840) begin bad++; $display("FAIL slew_integ16 got=%0h exp=840", integ); end
    @(negedge clk);
    total++; if (freq_sel !== 4'd9) begin bad++; $display("FAIL slew_freq got=%0d exp=9", freq_sel); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 1100; i++) strobe(1'b1);
    total++; if (integ !== 16'h0FFF) begin bad++; $display("FAIL sat_hi_integ got=%0h exp=fff", integ); end
    @(negedge clk);
    total++; if (freq_sel !== 4'd15) begin bad++; $display("FAIL sat_hi_freq got=%0d exp=15", freq_sel); end
    strobe(1'b0);
    total++; if (integ !== 16'h0FFB) begin bad++; $display("FAIL sat_down_integ got=%0h exp=ffb", integ); end
    @(negedge clk);
    total++; if (freq_sel !== 4'd14) begin bad++; $display("FAIL sat_down_freq got=%0d exp=14", freq_sel); end
    do_reset();
    for (int i = 0; i < 600; i++) strobe(1'b0);
    total++; if (integ !== 16'h0000) begin bad++; $display("FAIL sat_lo_integ got=%0h exp=0", integ); end
    @(negedge clk);
    total++; if (freq_sel !== 4'd0) begin bad++; $display("FAIL sat_lo_freq got=%0d exp=0", freq_sel); end
    strobe(1'b1);
    @(negedge clk);
    total++; if (freq_sel !== 4'd1) begin bad++; $display("FAIL sat_lo_up_freq got=%0d exp=1", freq_sel); end
  endtask

  task automatic test_lock();
    do_reset();
    for (int i = 0; i < 32; i++) strobe((i % 2) == 0);
    total++; if (lock !== 1'b0) begin bad++; $display("FAIL lock_32 got=%0b exp=0", lock); end
    strobe(1'b1);
    total++; if (lock !== LOCK_ON) begin bad++; $display("FAIL lock_33 got=%0b exp=%0b", lock, LOCK_ON); end
    strobe(1'b0);
    total++; if (lock !== LOCK_ON) begin bad++; $display("FAIL lock_hold got=%0b exp=%0b", lock, LOCK_ON); end
    strobe(1'b0);
    total++; if (lock !== 1'b0) begin bad++; $display("FAIL lock_drop got=%0b exp=0", lock); end
    total++; if (integ !== 16'h07FC) begin bad++; $display("FAIL lock_integ got=%0h exp=7fc", integ); end
    @(negedge clk);
    total++; if (freq_sel !== 4'd6) begin bad++; $display("FAIL lock_freq got=%0d exp=6", freq_sel); end
  endtask

  task automatic test_enable();
    do_reset();
    for (int i = 0; i < 33; i++) strobe((i % 2) == 0);
    total++; if (lock !== LOCK_ON) begin bad++; $display("FAIL en_prelock got=%0b exp=%0b", lock, LOCK_ON); end
    enable = 1'b0;
    for (int i = 0; i < 5; i++) strobe(1'b1);
    total++; if (lock !== 1'b0) begin bad++; $display("FAIL dis_lock got=%0b exp=0", lock); end
    total++; if (integ !== 16'h0804) begin bad++; $display("FAIL dis_integ got=%0h exp=804", integ); end
    total++; if (freq_sel !== 4'd7) begin bad++; $display("FAIL dis_freq got=%0d exp=7", freq_sel); end
    enable = 1'b1;
    @(negedge clk);
    total++; if (freq_sel !== 4'd9) begin bad++; $display("FAIL reen_freq got=%0d exp=9", freq_sel); end
    for (int i = 0; i < 32; i++) strobe((i % 2) == 1);
    total++; if (lock !== 1'b0) begin bad++; $display("FAIL relock_32 got=%0b exp=0", lock); end
    strobe(1'b0);
    total++; if (lock !== LOCK_ON) begin bad++; $display("FAIL relock_33 got=%0b exp=%0b", lock, LOCK_ON); end
  endtask

  task automatic test_reset_strobe();
    reset = 1'b1;
    pd_valid = 1'b1;
    pd_up = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    pd_valid = 1'b0;
    total++; if (integ !== 16'h0800) begin bad++; $display("FAIL rst_strobe_integ got=%0h exp=800", integ); end
    total++; if (freq_sel !== 4'd8) begin bad++; $display("FAIL rst_strobe_freq got=%0d exp=8", freq_sel); end
    total++; if (lock !== 1'b0) begin bad++; $display("FAIL rst_strobe_lock got=%0b exp=0", lock); end
    @(negedge clk);
    @(negedge clk);
    total++; if (integ !== 16'h0800) begin bad++; $display("FAIL rst_dropped_integ got=%0h exp=800", integ); end
    total++; if (freq_sel !== 4'd8) begin bad++; $display("FAIL rst_dropped_freq got=%0d exp=8", freq_sel); end
  endtask

  initial begin
    test_reset();
    test_slew();
    test_saturation();
    test_lock();
    test_enable();
    test_reset_strobe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
